// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between result producers and the register-file write port.
//   alu_*      : single-cycle ALU result handshake (valid/ready, addr, data)
//   mem_*      : variable-latency memory/multicycle result handshake
//   we/waddr/wdata : registered register-file write port
//   chk_addr/chk_pending : hazard query, present only with WB_PENDING_EN
// Modports: master = producers and register file side, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
`ifdef WB_PENDING_EN
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_pending;
`endif

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    input  alu_ready, mem_ready,
    input  we, waddr, wdata
`ifdef WB_PENDING_EN
    ,
    output chk_addr,
    input  chk_pending
`endif
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    output alu_ready, mem_ready,
    output we, waddr, wdata
`ifdef WB_PENDING_EN
    ,
    input  chk_addr,
    output chk_pending
`endif
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Merges ALU results (priority) and buffered memory results into one registered
// write per cycle; a starvation limiter stalls the ALU so the FIFO always drains.
// Writes to register 0 are filtered here.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rf_wb_arbiter_if.slave (ALU/mem handshakes, we/waddr/wdata,
//          optional chk_addr/chk_pending)
// Optional feature macro: WB_PENDING_EN (hazard query port and match logic).
module rf_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic fifo_full, fifo_empty;
  logic alu_hs, mem_hs, push, pop;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Readiness comes from registered state only; a same-cycle pop never frees a slot.
  assign bus.mem_ready = !rst && !fifo_full;
  assign bus.alu_ready = !rst && (starve_q != StW'(STARVE_LIMIT));

  assign alu_hs = bus.alu_valid && bus.alu_ready;
  assign mem_hs = bus.mem_valid && bus.mem_ready;
  // Results for register 0 complete the handshake but are dropped.
  assign push   = mem_hs && (bus.mem_waddr != '0);
  // Pop decision uses the registered count, so a fresh push is never fall-through.
  assign pop    = !rst && !alu_hs && !fifo_empty;

  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    count_d  = count_q;

    if (alu_hs) begin
      we_d    = (bus.alu_waddr != '0);
      waddr_d = bus.alu_waddr;
      wdata_d = bus.alu_wdata;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end

    if (alu_hs && !fifo_empty) begin
      starve_d = starve_q + 1'b1;
    end else if (pop || fifo_empty) begin
      starve_d = '0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_addr_q[wr_ptr_q] <= bus.mem_waddr;
      fifo_data_q[wr_ptr_q] <= bus.mem_wdata;
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

`ifdef WB_PENDING_EN
  logic [PtrW-1:0] chk_idx;
  logic            chk_hit;

  // Walk entries from the head; only the first count_q slots hold live data.
  always_comb begin
    chk_hit = we_q && (waddr_q == bus.chk_addr);
    chk_idx = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      chk_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (fifo_addr_q[chk_idx] == bus.chk_addr)) begin
        chk_hit = 1'b1;
      end
    end
  end

  assign bus.chk_pending = !rst && (bus.chk_addr != '0) && chk_hit;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int unsigned DataW  = 32;
  localparam int unsigned AddrW  = 5;
  localparam int unsigned Depth  = 4;
  localparam int unsigned Starve = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rf_wb_arbiter_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  rf_wb_arbiter #(
    .DATA_W      (DataW),
    .ADDR_W      (AddrW),
    .FIFO_DEPTH  (Depth),
    .STARVE_LIMIT(Starve)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered results in arrival order plus the visible write port.
  typedef struct {
    logic [AddrW-1:0] a;
    logic [DataW-1:0] d;
  } ent_t;

  ent_t             q[$];
  int               starve;
  logic             m_we;
  logic [AddrW-1:0] m_waddr;
  logic [DataW-1:0] m_wdata;

  // One clock cycle: drive inputs, check handshake outputs, advance model, check write port.
  task automatic cycle(input logic r, input logic av, input logic [AddrW-1:0] aa,
                       input logic [DataW-1:0] ad, input logic mv,
                       input logic [AddrW-1:0] ma, input logic [DataW-1:0] md,
                       input logic [AddrW-1:0] ca);
    logic e_ar, e_mr, was_empty;
    ent_t e;
    rst           = r;
    bus.alu_valid = av;
    bus.alu_waddr = aa;
    bus.alu_wdata = ad;
    bus.mem_valid = mv;
    bus.mem_waddr = ma;
    bus.mem_wdata = md;
`ifdef WB_PENDING_EN
    bus.chk_addr  = ca;
`endif
    #1;
    e_ar = !r && (starve != Starve);
    e_mr = !r && (q.size() != Depth);
    checks++;
    assert (bus.alu_ready === e_ar) else begin
      failures++;
      $error("FAIL alu_ready got=%b exp=%b t=%0t", bus.alu_ready, e_ar, $time);
    end
    checks++;
    assert (bus.mem_ready === e_mr) else begin
      failures++;
      $error("FAIL mem_ready got=%b exp=%b t=%0t", bus.mem_ready, e_mr, $time);
    end
`ifdef WB_PENDING_EN
    begin
      logic e_cp;
      e_cp = 1'b0;
      if (!r && ca != '0) begin
        if (m_we && m_waddr == ca) e_cp = 1'b1;
        foreach (q[i]) if (q[i].a == ca) e_cp = 1'b1;
      end
      checks++;
      assert (bus.chk_pending === e_cp) else begin
        failures++;
        $error("FAIL chk_pending got=%b exp=%b t=%0t", bus.chk_pending, e_cp, $time);
      end
    end
`else
    if (ca != '0) begin end
`endif
    if (r) begin
      q.delete();
      starve  = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      was_empty = (q.size() == 0);
      if (av && e_ar) begin
        m_we    = (aa != '0);
        m_waddr = aa;
        m_wdata = ad;
        starve  = was_empty ? 0 : starve + 1;
      end else if (!was_empty) begin
        e       = q.pop_front();
        m_we    = 1'b1;
        m_waddr = e.a;
        m_wdata = e.d;
        starve  = 0;
      end else begin
        m_we   = 1'b0;
        starve = 0;
      end
      if (mv && e_mr && ma != '0) begin
        e.a = ma;
        e.d = md;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (bus.we === m_we) else begin
      failures++;
      $error("FAIL we got=%b exp=%b t=%0t", bus.we, m_we, $time);
    end
    checks++;
    assert (bus.waddr === m_waddr) else begin
      failures++;
      $error("FAIL waddr got=%0d exp=%0d t=%0t", bus.waddr, m_waddr, $time);
    end
    checks++;
    assert (bus.wdata === m_wdata) else begin
      failures++;
      $error("FAIL wdata got=%h exp=%h t=%0t", bus.wdata, m_wdata, $time);
    end
  endtask

  task automatic idle(input int n, input logic [AddrW-1:0] ca);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ca);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    starve   = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    rst      = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_waddr = '0;
    bus.alu_wdata = '0;
    bus.mem_valid = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
`ifdef WB_PENDING_EN
    bus.chk_addr  = '0;
`endif
    @(posedge clk);
    #1;

    // Reset then a single ALU write.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b1, 5'd1, 32'h1234_5678, 1'b0, '0, '0, 5'd1);
    idle(2, 5'd1);

    // Writes to $0 from both sources never reach the register file.
    cycle(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h5555_0000, 5'd0);
    idle(2, 5'd0);

    // Four mem results under continuous ALU traffic exercise the starvation limiter.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 5'd20, 32'hC0 + i, 1'b1, AddrW'(2 + i), DataW'(32'hA0 + i), 5'd2);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b1, 5'd21, 32'hD0 + i, 1'b0, '0, '0, 5'd5);
    idle(3, '0);

    // Fill under ALU pressure, then pop with mem_valid held while full (pointer wrap).
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 5'd22, 32'hE0 + i, 1'b1, AddrW'(10 + i), DataW'(i), 5'd12);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AddrW'(16 + i), DataW'(32'h100 + i), 5'd17);
    idle(8, 5'd18);

    // Reset with results buffered discards all of them.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 5'd23, 32'hF0 + i, 1'b1, AddrW'(24 + i), DataW'(32'hB0 + i), 5'd24);
    cycle(1'b1, 1'b1, 5'd23, 32'hFF, 1'b1, 5'd27, 32'hBB, 5'd24);
    idle(5, 5'd24);

    // Hazard query across the push, write and retire of reg 7.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 5'd7);
    idle(3, 5'd7);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 99) < 55),
            AddrW'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 99) < 45),
            AddrW'($urandom_range(0, 7)),
            $urandom,
            AddrW'($urandom_range(0, 7)));
    end
    idle(10, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Writeback-side driver for the 32x32 register file's single write port (we/waddr/wdata). It merges single-cycle ALU results and variable-latency memory/multicycle results into one registered write per cycle. Memory results are buffered in a small FIFO, and a starvation limiter keeps ALU priority from blocking them forever. Writes to $0 are filtered here, so the register file never sees a write enable for $0.

Parameters:
DATA_W, 32, data width of write port and result buses
ADDR_W, 5, register address width
FIFO_DEPTH, 4, memory-result buffer entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive ALU-won cycles with a non-empty FIFO before ALU is back-pressured

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle when alu_valid&&alu_ready
alu_waddr  input  ADDR_W  ALU destination register
alu_wdata  input  DATA_W  ALU result
mem_valid  input  1  memory/multicycle result valid
mem_ready  output  1  FIFO can accept; transfer on mem_valid&&mem_ready
mem_waddr  input  ADDR_W  memory-result destination register
mem_wdata  input  DATA_W  memory result
we  output  1  register-file write enable (registered)
waddr  output  ADDR_W  register-file write address (registered)
wdata  output  DATA_W  register-file write data (registered)
chk_addr  input  ADDR_W  hazard query address (WB_PENDING_EN only)
chk_pending  output  1  query hit (WB_PENDING_EN only)

Behaviour:
- Reset (rst=1 at a clk edge): FIFO flushed (count=0, pointers=0), starve_cnt=0, and we/waddr/wdata all 0. While rst=1, alu_ready=0 and mem_ready=0 (combinationally gated). Reset mid-operation discards every buffered result.
- mem_ready = !full, derived from the registered count; it is not recomputed from a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
- alu_ready = (starve_cnt != STARVE_LIMIT).
- Enqueue: a mem handshake pushes {mem_waddr, mem_wdata}. If mem_waddr==0, the handshake completes but nothing is stored.
- Per-cycle arbitration; at most one write is issued:
  1. An ALU handshake wins. The next cycle shows we=(alu_waddr!=0), waddr=alu_waddr, wdata=alu_wdata.
  2. Otherwise, if the FIFO is non-empty: pop the head. The next cycle shows we=1 with the head's address and data.
  3. Otherwise: we=0 next cycle. waddr and wdata hold their previous values.
- Latency: exactly 1 cycle from handshake (or pop) to we. FIFO entries drain in arrival order.
- Simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged and pointers advance. A push into an empty FIFO is not poppable until the following cycle (no fall-through).
- starve_cnt: increments when an ALU write wins while the FIFO is non-empty. It clears on a pop, or when the FIFO is empty.
- At starve_cnt==STARVE_LIMIT, the ALU is stalled for exactly one cycle and the FIFO head is popped.
- Pointer wrap-around uses modulo FIFO_DEPTH. count runs 0..FIFO_DEPTH.

Optional Feature:
WB_PENDING_EN
- Defined: chk_addr and chk_pending ports exist. chk_pending is combinational and is 1 iff chk_addr!=0 and matches either a valid FIFO entry or the output register (we=1 && waddr==chk_addr). It lets decode stall on a register that is still being written back. chk_pending is 0 during reset.
- Undefined: these ports and the match logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then a single ALU write: alu_valid=1, waddr=1, wdata=0x12345678 -> next cycle we=1, waddr=1, wdata=0x12345678; the cycle after, we=0.
- ALU write to $0 with 0xDEADBEEF, and mem write to $0 -> we never asserts, FIFO count stays 0, and mem_ready stays 1.
- Push 4 mem results (regs 2..5, data 0xA0..0xA3) while alu_valid=1 continuously -> mem_ready=0 after the 4th push. The ALU wins 3 cycles, then alu_ready=0 for 1 cycle and reg 2=0xA0 is written. The remaining entries drain in order, each after another 3 ALU wins.
- FIFO full while simultaneously popping (alu_valid=0) and mem_valid=1 -> no push that cycle; mem_ready=1 the next cycle and the push succeeds. Entries 0..5 cover pointer wrap, and the written order matches the push order.
- Assert rst with 3 entries buffered -> the next cycle we=0, count=0, mem_ready=1, and none of the 3 entries is ever written.
- WB_PENDING_EN: push mem reg 7, chk_addr=7 -> chk_pending=1 through the write cycle and 0 the cycle after. chk_addr=0 -> always 0.
